// File: rtl/ex_stage_if.sv
// ID/EX operand and control bundle into the execute stage, and the EX/MEM
// register contents out of it.
interface ex_stage_if;
  logic [1:0]  ctlwb_in;
  logic [2:0]  ctlm_in;
  logic        regdst;
  logic [1:0]  aluop;
  logic        alusrc;
  logic [31:0] npc;
  logic [31:0] readdat1;
  logic [31:0] readdat2;
  logic [31:0] sign_ext;
  logic [5:0]  funct;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;

  logic [1:0]  mem_ctlwb_out;
  logic [2:0]  mem_ctlm_out;
  logic [31:0] mem_add_result;
  logic        mem_zero;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata2;
  logic [4:0]  mem_write_reg;

  // Upstream side: drives the ID/EX values and observes EX/MEM.
  modport master (
    output ctlwb_in, ctlm_in, regdst, aluop, alusrc, npc, readdat1, readdat2,
           sign_ext, funct, instr_2016, instr_1511,
    input  mem_ctlwb_out, mem_ctlm_out, mem_add_result, mem_zero, mem_alu_result,
           mem_rdata2, mem_write_reg
  );

  modport slave (
    input  ctlwb_in, ctlm_in, regdst, aluop, alusrc, npc, readdat1, readdat2,
           sign_ext, funct, instr_2016, instr_1511,
    output mem_ctlwb_out, mem_ctlm_out, mem_add_result, mem_zero, mem_alu_result,
           mem_rdata2, mem_write_reg
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control decode, ALU, branch-target add, destination
// select, and the EX/MEM pipeline register with reset > flush > stall priority.
module ex_stage #(
  parameter int unsigned BRANCH_SHIFT = 0
) (
  input logic      clk,
  input logic      reset,
  input logic      stall,
  input logic      flush,
  ex_stage_if.slave bus
);

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNop = 4'b1111;

  typedef struct packed {
    logic [1:0]  ctlwb;
    logic [2:0]  ctlm;
    logic [31:0] add_result;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  write_reg;
  } ex_mem_t;

  logic [3:0]  alu_ctl;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  ex_mem_t     calc;
  ex_mem_t     ex_mem_d, ex_mem_q;

  always_comb begin
    alu_ctl = AluNop;
    unique case (bus.aluop)
      2'b00: alu_ctl = AluAdd;
      2'b01: alu_ctl = AluSub;
      2'b10: begin
        case (bus.funct)
          6'b100000: alu_ctl = AluAdd;
          6'b100010: alu_ctl = AluSub;
          6'b100100: alu_ctl = AluAnd;
          6'b100101: alu_ctl = AluOr;
          6'b101010: alu_ctl = AluSlt;
          default:   alu_ctl = AluNop;
        endcase
      end
      default: alu_ctl = AluNop;
    endcase
  end

  assign op_b = bus.alusrc ? bus.sign_ext : bus.readdat2;

  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      AluAnd:  alu_result = bus.readdat1 & op_b;
      AluOr:   alu_result = bus.readdat1 | op_b;
      AluAdd:  alu_result = bus.readdat1 + op_b;
      AluSub:  alu_result = bus.readdat1 - op_b;
      AluSlt:  alu_result = {31'b0, $signed(bus.readdat1) < $signed(op_b)};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    calc.ctlwb      = bus.ctlwb_in;
    calc.ctlm       = bus.ctlm_in;
    calc.add_result = bus.npc + (bus.sign_ext << BRANCH_SHIFT);
    calc.zero       = (alu_result == 32'd0);
    calc.alu_result = alu_result;
    calc.rdata2     = bus.readdat2;
    calc.write_reg  = bus.regdst ? bus.instr_1511 : bus.instr_2016;
  end

  // A flush bubble is all zeros, so it carries regwrite/memwrite/branch = 0.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (flush) begin
      ex_mem_d = '0;
    end else if (!stall) begin
      ex_mem_d = calc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign bus.mem_ctlwb_out  = ex_mem_q.ctlwb;
  assign bus.mem_ctlm_out   = ex_mem_q.ctlm;
  assign bus.mem_add_result = ex_mem_q.add_result;
  assign bus.mem_zero       = ex_mem_q.zero;
  assign bus.mem_alu_result = ex_mem_q.alu_result;
  assign bus.mem_rdata2     = ex_mem_q.rdata2;
  assign bus.mem_write_reg  = ex_mem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed check of ex_stage against an instruction-level
// reference model of the execute stage and EX/MEM register.
module tb_ex_stage;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic flush;

  ex_stage_if bus ();

  ex_stage #(
    .BRANCH_SHIFT(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected EX/MEM contents.
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [31:0] e_add;
  logic        e_zero;
  logic [31:0] e_alu;
  logic [31:0] e_rd2;
  logic [4:0]  e_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Instruction-level meaning of the current inputs.
  function automatic logic [31:0] ref_alu();
    logic [31:0] a;
    logic [31:0] b;
    a = bus.readdat1;
    b = bus.alusrc ? bus.sign_ext : bus.readdat2;
    if (bus.aluop == 2'b00) return a + b;
    if (bus.aluop == 2'b01) return a - b;
    if (bus.aluop == 2'b11) return 32'd0;
    if (bus.funct == 6'd32) return a + b;
    if (bus.funct == 6'd34) return a - b;
    if (bus.funct == 6'd36) return a & b;
    if (bus.funct == 6'd37) return a | b;
    if (bus.funct == 6'd42) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    if (reset || flush) begin
      e_wb = '0; e_m = '0; e_add = '0; e_zero = 1'b0; e_alu = '0; e_rd2 = '0; e_wr = '0;
    end else if (!stall) begin
      r      = ref_alu();
      e_wb   = bus.ctlwb_in;
      e_m    = bus.ctlm_in;
      e_add  = bus.npc + bus.sign_ext;
      e_zero = (r == 32'd0);
      e_alu  = r;
      e_rd2  = bus.readdat2;
      e_wr   = bus.regdst ? bus.instr_1511 : bus.instr_2016;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb"},   32'(bus.mem_ctlwb_out),  32'(e_wb));
    check({tag, ".m"},    32'(bus.mem_ctlm_out),   32'(e_m));
    check({tag, ".add"},  bus.mem_add_result,      e_add);
    check({tag, ".zero"}, 32'(bus.mem_zero),       32'(e_zero));
    check({tag, ".alu"},  bus.mem_alu_result,      e_alu);
    check({tag, ".rd2"},  bus.mem_rdata2,          e_rd2);
    check({tag, ".wr"},   32'(bus.mem_write_reg),  32'(e_wr));
  endtask

  // One clock: inputs already applied, model and DUT advance, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    logic [5:0] fl [6];
    fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    bus.ctlwb_in   = 2'($urandom);
    bus.ctlm_in    = 3'($urandom);
    bus.regdst     = 1'($urandom);
    bus.aluop      = 2'($urandom);
    bus.alusrc     = 1'($urandom);
    bus.npc        = $urandom;
    bus.readdat1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
    bus.readdat2   = ($urandom_range(0, 3) == 0) ? bus.readdat1 : $urandom;
    bus.sign_ext   = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
    bus.funct      = fl[$urandom_range(0, 5)];
    if (bus.funct == 6'd0) bus.funct = 6'($urandom);
    bus.instr_2016 = 5'($urandom);
    bus.instr_1511 = 5'($urandom);
  endtask

  task automatic clear_inputs();
    bus.ctlwb_in = '0; bus.ctlm_in = '0; bus.regdst = 1'b0; bus.aluop = '0;
    bus.alusrc = 1'b0; bus.npc = '0; bus.readdat1 = '0; bus.readdat2 = '0;
    bus.sign_ext = '0; bus.funct = '0; bus.instr_2016 = '0; bus.instr_1511 = '0;
  endtask

  task automatic load_add_case();
    clear_inputs();
    bus.aluop = 2'b10; bus.funct = 6'b100000; bus.regdst = 1'b1; bus.alusrc = 1'b0;
    bus.readdat1 = 32'h64; bus.readdat2 = 32'h64; bus.instr_1511 = 5'd2;
    bus.ctlwb_in = 2'b10;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_inputs();
    step("reset0");
    rand_inputs();
    step("reset1");
    check("reset.alu_zero", bus.mem_alu_result, 32'd0);

    reset = 1'b0;
    load_add_case();
    step("radd");
    check("radd.c8", bus.mem_alu_result, 32'hC8);
    check("radd.wr", 32'(bus.mem_write_reg), 32'd2);

    clear_inputs();
    bus.aluop = 2'b01; bus.readdat1 = 32'd5; bus.readdat2 = 32'd5;
    bus.npc = 32'd2; bus.sign_ext = 32'd8; bus.ctlm_in = 3'b100;
    step("beq");
    check("beq.target", bus.mem_add_result, 32'hA);
    check("beq.zero", 32'(bus.mem_zero), 32'd1);

    clear_inputs();
    bus.aluop = 2'b00; bus.alusrc = 1'b1; bus.readdat1 = 32'h64; bus.sign_ext = 32'd2;
    bus.readdat2 = 32'h77; bus.regdst = 1'b0; bus.instr_2016 = 5'd2; bus.instr_1511 = 5'd9;
    step("lwsw");
    check("lwsw.addr", bus.mem_alu_result, 32'h66);
    check("lwsw.rd2", bus.mem_rdata2, 32'h77);

    clear_inputs();
    bus.aluop = 2'b10; bus.funct = 6'b101010; bus.readdat1 = 32'hFFFF_FFFF; bus.readdat2 = 32'd1;
    step("slt");
    check("slt.one", bus.mem_alu_result, 32'd1);
    bus.readdat1 = 32'd1; bus.readdat2 = 32'hFFFF_FFFF;
    step("sltswap");
    check("sltswap.zero", 32'(bus.mem_zero), 32'd1);

    // Unknown funct and aluop 11 both produce 0 with zero set.
    bus.funct = 6'b000111; bus.readdat1 = 32'd3;
    step("badfunct");
    bus.aluop = 2'b11;
    step("aluop11");

    load_add_case();
    step("hold.load");
    stall = 1'b1;
    rand_inputs();
    step("hold0");
    rand_inputs();
    step("hold1");
    check("hold.c8", bus.mem_alu_result, 32'hC8);
    flush = 1'b1;
    step("stallflush");
    check("stallflush.wb", 32'(bus.mem_ctlwb_out), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Reset mid-stream overrides stall and flush.
    load_add_case();
    step("pre_reset");
    reset = 1'b1; stall = 1'b1;
    step("mid_reset");
    reset = 1'b0; stall = 1'b0;
    rand_inputs();
    step("post_reset");

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 4) == 0);
      rand_inputs();
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
